// File: rtl/sqrt_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_result_collector
// Brief    : Per-slot reorder buffer that gathers results from N workers and
//            releases them in round-robin dispatch order (valid/ready).
//            Optional macro COLLECTOR_OVF_CHECK_EN enables sticky ovf_err.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_result_collector #(
    parameter int N_SLOTS = 8,
    parameter int W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SLOTS-1:0]           wrk_res_vld,
    input  logic [N_SLOTS*W-1:0]         wrk_res,
    output logic [N_SLOTS-1:0]           slot_full,
    output logic [$clog2(N_SLOTS+1)-1:0] occupancy,
    output logic                         res_vld,
    input  logic                         res_rdy,
    output logic [W-1:0]                 res,
    output logic [$clog2(N_SLOTS)-1:0]   rd_ptr,
    output logic                         ovf_err
);
    localparam int                PTR_W       = $clog2(N_SLOTS);
    localparam int                OCC_W       = $clog2(N_SLOTS + 1);
    localparam logic [PTR_W-1:0]  C_LAST_SLOT = PTR_W'(N_SLOTS - 1);

    logic [N_SLOTS-1:0] slot_full_q, slot_full_d;
    logic [OCC_W-1:0]   occupancy_q, occupancy_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]       data_q [N_SLOTS];

    logic               w_pop;
    logic [N_SLOTS-1:0] w_pop_mask;
    logic [N_SLOTS-1:0] w_accept;
    logic [OCC_W-1:0]   w_acc_cnt;

    assign w_pop = slot_full_q[rd_ptr_q] & res_rdy;

    // A full slot only accepts new data when it is being popped in the same cycle.
    always_comb begin
        w_pop_mask = '0;
        w_accept   = '0;
        w_acc_cnt  = '0;
        if (w_pop) begin
            w_pop_mask[rd_ptr_q] = 1'b1;
        end
        for (int i = 0; i < N_SLOTS; i++) begin
            w_accept[i] = wrk_res_vld[i] & (~slot_full_q[i] | w_pop_mask[i]);
            w_acc_cnt   = w_acc_cnt + OCC_W'(w_accept[i]);
        end
        slot_full_d = (slot_full_q & ~w_pop_mask) | w_accept;
        occupancy_d = occupancy_q + w_acc_cnt - OCC_W'(w_pop);
        rd_ptr_d    = rd_ptr_q;
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == C_LAST_SLOT) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full_q <= '0;
            occupancy_q <= '0;
            rd_ptr_q    <= '0;
        end else begin
            slot_full_q <= slot_full_d;
            occupancy_q <= occupancy_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SLOTS; i++) begin
            if (w_accept[i]) begin
                data_q[i] <= wrk_res[i*W +: W];
            end
        end
    end

    assign slot_full = slot_full_q;
    assign occupancy = occupancy_q;
    assign rd_ptr    = rd_ptr_q;
    assign res_vld   = slot_full_q[rd_ptr_q];
    assign res       = data_q[rd_ptr_q];

`ifdef COLLECTOR_OVF_CHECK_EN
    logic [N_SLOTS-1:0] w_ovf;
    logic               ovf_err_q, ovf_err_d;

    always_comb begin
        w_ovf     = wrk_res_vld & slot_full_q & ~w_pop_mask;
        ovf_err_d = ovf_err_q | (|w_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_ovf[i]) begin
                    $error("sqrt_result_collector: overflow on slot %0d", i);
                end
            end
        end
    end
`endif
`else
    assign ovf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sqrt_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_result_collector
// Brief    : Scoreboard bench for sqrt_result_collector (N=8 and N=5 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_result_collector;
    typedef struct {
        logic [2:0]  ptr;
        logic [31:0] val;
    } exp_t;

`ifdef COLLECTOR_OVF_CHECK_EN
    localparam logic C_OVF_EXP = 1'b1;
`else
    localparam logic C_OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]   vld8  = '0;
    logic [255:0] wres8 = '0;
    logic         rdy8  = 1'b0;
    logic [7:0]   full8;
    logic [3:0]   occ8;
    logic         res_vld8;
    logic [31:0]  res8;
    logic [2:0]   ptr8;
    logic         ovf8;

    logic [4:0]   vld5  = '0;
    logic [159:0] wres5 = '0;
    logic         rdy5  = 1'b0;
    logic [4:0]   full5;
    logic [2:0]   occ5;
    logic         res_vld5;
    logic [31:0]  res5;
    logic [2:0]   ptr5;
    logic         ovf5;

    sqrt_result_collector #(.N_SLOTS(8), .W(32)) u8 (
        .clk(clk), .rst(rst), .wrk_res_vld(vld8), .wrk_res(wres8),
        .slot_full(full8), .occupancy(occ8), .res_vld(res_vld8),
        .res_rdy(rdy8), .res(res8), .rd_ptr(ptr8), .ovf_err(ovf8)
    );

    sqrt_result_collector #(.N_SLOTS(5), .W(32)) u5 (
        .clk(clk), .rst(rst), .wrk_res_vld(vld5), .wrk_res(wres5),
        .slot_full(full5), .occupancy(occ5), .res_vld(res_vld5),
        .res_rdy(rdy5), .res(res5), .rd_ptr(ptr5), .ovf_err(ovf5)
    );

    exp_t q8[$];
    exp_t q5[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push8(input int p, input logic [31:0] v);
        exp_t e;
        e.ptr = 3'(p);
        e.val = v;
        q8.push_back(e);
    endtask

    task automatic push5(input int p, input logic [31:0] v);
        exp_t e;
        e.ptr = 3'(p);
        e.val = v;
        q5.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one8(input int s, input logic [31:0] v);
        vld8 = '0;
        vld8[s] = 1'b1;
        wres8[s*32 +: 32] = v;
    endtask

    task automatic one5(input int s, input logic [31:0] v);
        vld5 = '0;
        vld5[s] = 1'b1;
        wres5[s*32 +: 32] = v;
    endtask

    task automatic do_reset();
        vld8 = '0;
        vld5 = '0;
        rst  = 1'b1;
        step();
        rst  = 1'b0;
    endtask

    // Monitors: every accepted handshake is matched against the scoreboard.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst && res_vld8 && rdy8) begin
            if (q8.size() == 0) begin
                chk("mon8_unexpected", res8, 32'hFFFF_FFFF);
            end else begin
                e = q8.pop_front();
                chk("mon8_res", res8, e.val);
                chk("mon8_ptr", 32'(ptr8), 32'(e.ptr));
            end
        end
    end

    always @(negedge clk) begin : mon5
        exp_t e;
        if (!rst && res_vld5 && rdy5) begin
            if (q5.size() == 0) begin
                chk("mon5_unexpected", res5, 32'hFFFF_FFFF);
            end else begin
                e = q5.pop_front();
                chk("mon5_res", res5, e.val);
                chk("mon5_ptr", 32'(ptr5), 32'(e.ptr));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_full8", 32'(full8), 32'h0);
        chk("rst_occ8", 32'(occ8), 32'h0);
        chk("rst_ptr8", 32'(ptr8), 32'h0);
        chk("rst_vld8", 32'(res_vld8), 32'h0);
        chk("rst_ovf8", 32'(ovf8), 32'h0);
        chk("rst_full5", 32'(full5), 32'h0);
        step();
        rst = 1'b0;

        // In-order: slots 0..3 capture 10..13 with res_rdy held high
        rdy8 = 1'b1;
        for (int k = 0; k < 4; k++) push8(k, 32'(10 + k));
        for (int k = 0; k < 4; k++) begin
            one8(k, 32'(10 + k));
            step();
        end
        vld8 = '0;
        step();
        step();
        @(negedge clk);
        chk("inorder_ptr", 32'(ptr8), 32'd4);
        chk("inorder_occ", 32'(occ8), 32'd0);

        // Reorder: slot 2, then 1, then 0
        step();
        do_reset();
        push8(0, 32'h00);
        push8(1, 32'h11);
        push8(2, 32'h22);
        rdy8 = 1'b1;
        one8(2, 32'h22);
        step();
        one8(1, 32'h11);
        @(negedge clk);
        chk("reorder_wait_t0", 32'(res_vld8), 32'd0);
        step();
        one8(0, 32'h00);
        @(negedge clk);
        chk("reorder_wait_t1", 32'(res_vld8), 32'd0);
        step();
        vld8 = '0;
        @(negedge clk);
        chk("reorder_first", 32'(res_vld8), 32'd1);
        step();
        @(negedge clk);
        chk("reorder_second", 32'(res_vld8), 32'd1);
        step();
        @(negedge clk);
        chk("reorder_third", 32'(res_vld8), 32'd1);
        step();
        @(negedge clk);
        chk("reorder_empty", 32'(res_vld8), 32'd0);
        chk("reorder_occ", 32'(occ8), 32'd0);

        // Backpressure: 5 and 6 held while res_rdy=0
        step();
        do_reset();
        rdy8 = 1'b0;
        vld8 = 8'h03;
        wres8[31:0]  = 32'd5;
        wres8[63:32] = 32'd6;
        step();
        vld8 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_vld", 32'(res_vld8), 32'd1);
            chk("bp_res", res8, 32'd5);
            chk("bp_occ", 32'(occ8), 32'd2);
            step();
        end
        push8(0, 32'd5);
        push8(1, 32'd6);
        rdy8 = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("bp_drain_occ", 32'(occ8), 32'd0);
        chk("bp_drain_ptr", 32'(ptr8), 32'd2);
        step();
        rdy8 = 1'b0;

        // Wrap on N=5: 12 in-order results
        do_reset();
        rdy5 = 1'b1;
        for (int k = 0; k < 12; k++) push5(k % 5, 32'(100 + k));
        for (int k = 0; k < 12; k++) begin
            one5(k % 5, 32'(100 + k));
            step();
        end
        vld5 = '0;
        step();
        step();
        @(negedge clk);
        chk("wrap_ptr", 32'(ptr5), 32'd2);
        chk("wrap_occ", 32'(occ5), 32'd0);

        // Same-slot capture and pop on slot 0
        step();
        do_reset();
        rdy5 = 1'b0;
        one5(0, 32'hA0);
        step();
        vld5 = '0;
        @(negedge clk);
        chk("cp_pre_res", res5, 32'hA0);
        step();
        push5(0, 32'hA0);
        rdy5 = 1'b1;
        one5(0, 32'hB0);
        step();
        rdy5 = 1'b0;
        vld5 = '0;
        @(negedge clk);
        chk("cp_full", 32'(full5), 32'h01);
        chk("cp_occ", 32'(occ5), 32'd1);
        chk("cp_ptr", 32'(ptr5), 32'd1);
        chk("cp_ovf", 32'(ovf5), 32'd0);
        step();
        for (int k = 1; k < 5; k++) push5(k, 32'(32'hC0 + k));
        push5(0, 32'hB0);
        rdy5 = 1'b1;
        vld5 = 5'b11110;
        for (int k = 1; k < 5; k++) wres5[k*32 +: 32] = 32'(32'hC0 + k);
        step();
        vld5 = '0;
        repeat (6) step();
        @(negedge clk);
        chk("cp_drain_occ", 32'(occ5), 32'd0);
        chk("cp_drain_ptr", 32'(ptr5), 32'd1);
        step();
        rdy5 = 1'b0;

        // Overflow: 0xBAD into full slot 3 is dropped
        do_reset();
        rdy8 = 1'b0;
        vld8 = 8'h0F;
        for (int k = 0; k < 4; k++) wres8[k*32 +: 32] = 32'(32'h30 + k);
        step();
        one8(3, 32'hBAD);
        step();
        vld8 = '0;
        @(negedge clk);
        chk("ovf_flag", 32'(ovf8), 32'(C_OVF_EXP));
        chk("ovf_occ", 32'(occ8), 32'd4);
        chk("ovf_full", 32'(full8), 32'h0F);
        step();
        for (int k = 0; k < 4; k++) push8(k, 32'(32'h30 + k));
        rdy8 = 1'b1;
        repeat (5) step();
        @(negedge clk);
        chk("ovf_drain_occ", 32'(occ8), 32'd0);
        chk("ovf_sticky", 32'(ovf8), 32'(C_OVF_EXP));
        step();

        // Reset mid-run with three results buffered
        rdy8 = 1'b0;
        do_reset();
        push8(0, 32'd1);
        vld8 = 8'h0F;
        for (int k = 0; k < 4; k++) wres8[k*32 +: 32] = 32'(1 + k);
        step();
        vld8 = '0;
        rdy8 = 1'b1;
        step();
        rdy8 = 1'b0;
        @(negedge clk);
        chk("mid_occ", 32'(occ8), 32'd3);
        chk("mid_ptr", 32'(ptr8), 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_full", 32'(full8), 32'h0);
        chk("mid_rst_vld", 32'(res_vld8), 32'd0);
        chk("mid_rst_occ", 32'(occ8), 32'd0);
        chk("mid_rst_ptr", 32'(ptr8), 32'd0);
        step();
        rst = 1'b0;
        push8(0, 32'd7);
        rdy8 = 1'b1;
        one8(0, 32'd7);
        step();
        vld8 = '0;
        step();
        step();
        @(negedge clk);
        chk("mid_after_occ", 32'(occ8), 32'd0);

        chk("sb8_empty", 32'(q8.size()), 32'd0);
        chk("sb5_empty", 32'(q5.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
